// File: rtl/mouse_cursor_tracker.sv
// rtl/mouse_cursor_tracker.sv - absolute cursor position, button levels and click/move strobes from PS/2 packets
module mouse_cursor_tracker #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int COORD_WIDTH = 10,
    parameter int DELTA_WIDTH = 8,
    parameter int INIT_X      = 320,
    parameter int INIT_Y      = 240
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_packet_valid,
    input  logic                   i_left_btn,
    input  logic                   i_right_btn,
    input  logic                   i_x_overflow,
    input  logic                   i_y_overflow,
    input  logic                   i_x_sign,
    input  logic                   i_y_sign,
    input  logic [DELTA_WIDTH-1:0] i_dx,
    input  logic [DELTA_WIDTH-1:0] i_dy,
    input  logic                   i_recenter,
    output logic [COORD_WIDTH-1:0] o_x,
    output logic [COORD_WIDTH-1:0] o_y,
    output logic                   o_left_held,
    output logic                   o_right_held,
    output logic                   o_left_click,
    output logic                   o_right_click,
    output logic                   o_moved,
    output logic [7:0]             o_drop_cnt
);

    localparam int SW = COORD_WIDTH + 2;
    localparam logic signed [SW-1:0]   X_MAX  = SW'(SCREEN_W - 1);
    localparam logic signed [SW-1:0]   Y_MAX  = SW'(SCREEN_H - 1);
    localparam logic [COORD_WIDTH-1:0] X_INIT = COORD_WIDTH'(INIT_X);
    localparam logic [COORD_WIDTH-1:0] Y_INIT = COORD_WIDTH'(INIT_Y);

    typedef enum logic [1:0] {IDLE, CALC, UPDATE} state_t;
    state_t state, state_next;

    logic signed [DELTA_WIDTH:0] dx_r, dy_r;
    logic                        left_r, right_r;
    logic [COORD_WIDTH-1:0]      nx_r, ny_r;
    logic signed [SW-1:0]        sum_x, sum_y;
    logic [COORD_WIDTH-1:0]      clamp_x, clamp_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (i_recenter) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (i_packet_valid) state_next = CALC;
                CALC:    state_next = UPDATE;
                UPDATE:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // PS/2 reports +Y as up while the screen grows downward, hence the subtraction.
    always_comb begin
        sum_x = $signed({2'b00, o_x}) + $signed({{(SW-DELTA_WIDTH-1){dx_r[DELTA_WIDTH]}}, dx_r});
        sum_y = $signed({2'b00, o_y}) - $signed({{(SW-DELTA_WIDTH-1){dy_r[DELTA_WIDTH]}}, dy_r});
        clamp_x = sum_x[COORD_WIDTH-1:0];
        clamp_y = sum_y[COORD_WIDTH-1:0];
        if (sum_x[SW-1])        clamp_x = '0;
        else if (sum_x > X_MAX) clamp_x = X_MAX[COORD_WIDTH-1:0];
        if (sum_y[SW-1])        clamp_y = '0;
        else if (sum_y > Y_MAX) clamp_y = Y_MAX[COORD_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_x           <= X_INIT;
            o_y           <= Y_INIT;
            o_left_held   <= 1'b0;
            o_right_held  <= 1'b0;
            o_left_click  <= 1'b0;
            o_right_click <= 1'b0;
            o_moved       <= 1'b0;
            o_drop_cnt    <= 8'd0;
            dx_r          <= '0;
            dy_r          <= '0;
            left_r        <= 1'b0;
            right_r       <= 1'b0;
            nx_r          <= X_INIT;
            ny_r          <= Y_INIT;
        end else begin
            o_left_click  <= 1'b0;
            o_right_click <= 1'b0;
            o_moved       <= 1'b0;
            if (i_recenter) begin
                o_x     <= X_INIT;
                o_y     <= Y_INIT;
                o_moved <= (o_x != X_INIT) || (o_y != Y_INIT);
            end else begin
                case (state)
                    IDLE: if (i_packet_valid) begin
                        dx_r    <= i_x_overflow ? '0 : {i_x_sign, i_dx};
                        dy_r    <= i_y_overflow ? '0 : {i_y_sign, i_dy};
                        left_r  <= i_left_btn;
                        right_r <= i_right_btn;
                    end
                    CALC: begin
                        nx_r <= clamp_x;
                        ny_r <= clamp_y;
                    end
                    UPDATE: begin
                        o_x           <= nx_r;
                        o_y           <= ny_r;
                        o_moved       <= (nx_r != o_x) || (ny_r != o_y);
                        o_left_held   <= left_r;
                        o_right_held  <= right_r;
                        o_left_click  <= left_r & ~o_left_held;
                        o_right_click <= right_r & ~o_right_held;
                    end
                    default: ;
                endcase
                if (i_packet_valid && state != IDLE && o_drop_cnt != 8'hFF)
                    o_drop_cnt <= o_drop_cnt + 8'd1;
            end
        end
    end

endmodule
